scale_hsrc_gen: RTL

Horizontal source/coefficient generator for the scaler datapath. It consumes one input line of pixels and produces, per output pixel, a neighbour pair (a, b), 8-bit weights (a_coff, b_coff) and the pass-through vertical weights. These feed the 4-cycle weighted-sum unit in the scale path. It is the producer end of the a/b/coff/data_en/scale_en interface. A fixed-point DDA accumulator selects source positions, so both upscale and downscale are supported.

---
 rtl/scale_pkg.sv | 19 +
 rtl/scale_pos_acc.sv | 39 +++
 rtl/scale_hsrc_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/scale_pkg.sv
// Shared types and constants for the horizontal source/coefficient generator.
//   state_t    : line-processing FSM states
//   FRAC_BITS  : fractional bits of the DDA step and position
//   COFF_MAX   : full-scale weight; a_coff + b_coff always equals this
//   STEP_UNITY : step value for a 1:1 scale ratio
package scale_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int         FRAC_BITS  = 8;
    localparam logic [7:0] COFF_MAX   = 8'd255;
    localparam int         STEP_UNITY = 256;

endpackage

// File: rtl/scale_pos_acc.sv
// DDA position accumulator and output-pixel counter.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   clear            : restart at position 0, count 0 (line start)
//   advance          : add step to position and bump the output count
//   step             : source step per output pixel, fixed point
//   pos_int/pos_frac : integer and fractional parts of the position
//   k                : outputs produced so far on this line
module scale_pos_acc #(
    parameter int W_BITS    = 11,
    parameter int FRAC_BITS = 8
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          clear,
    input  logic                          advance,
    input  logic [W_BITS+FRAC_BITS-1:0]   step,
    output logic [W_BITS-1:0]             pos_int,
    output logic [FRAC_BITS-1:0]          pos_frac,
    output logic [W_BITS-1:0]             k
);

    localparam int PW = W_BITS + FRAC_BITS;

    logic [PW-1:0] pos;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || clear) begin
            pos <= '0;
            k   <= '0;
        end else if (advance) begin
            pos <= pos + step;
            k   <= k + W_BITS'(1);
        end
    end

    assign pos_int  = pos[PW-1:FRAC_BITS];
    assign pos_frac = pos[FRAC_BITS-1:0];

endmodule

// File: rtl/scale_hsrc_gen.sv
// Horizontal source/coefficient generator for the scaler datapath.
// Consumes one line of pixels and, per output pixel, emits a neighbour pair
// (a, b) with complementary weights selected by a fixed-point DDA, plus the
// per-line vertical weights for the downstream weighted-sum unit.
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   cfg_*                     : line configuration, latched on start-of-line
//   in_data/in_vld/in_sol     : input pixel stream; in_rdy accepts
//   a, b, a_coff, b_coff      : source pair and horizontal weights
//   a_coff_next, b_coff_next  : vertical weights, updated with each output
//   data_en                   : one-cycle output-pixel strobe
//   scale_en                  : data_en qualified by the line-keep flag
//
// state | meaning
// IDLE  | waiting for a start-of-line pixel; other pixels dropped
// FILL  | first pixel held, loading the second into the window
// RUN   | emitting outputs, sliding the window as the DDA advances
// DRAIN | all outputs done, swallowing the rest of the line
module scale_hsrc_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int W_BITS     = 11,
    parameter int FRAC_BITS  = 8
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic [W_BITS-1:0]        cfg_in_width,
    input  logic [W_BITS-1:0]        cfg_out_width,
    input  logic [W_BITS+7:0]        cfg_step,
    input  logic [7:0]               cfg_v_coff_a,
    input  logic [7:0]               cfg_v_coff_b,
    input  logic                     cfg_line_keep,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_vld,
    input  logic                     in_sol,
    output logic                     in_rdy,
    output logic [DATA_WIDTH-1:0]    a,
    output logic [DATA_WIDTH-1:0]    b,
    output logic [7:0]               a_coff,
    output logic [7:0]               b_coff,
    output logic [7:0]               a_coff_next,
    output logic [7:0]               b_coff_next,
    output logic                     data_en,
    output logic                     scale_en
);

    import scale_pkg::*;

    localparam int PW = W_BITS + 8;

    state_t                  state, next_state;

    logic [W_BITS-1:0]       in_q, out_q;
    logic [PW-1:0]           step_q;
    logic [7:0]              va_q, vb_q;
    logic                    keep_q;

    logic [DATA_WIDTH-1:0]   win0, win1;
    logic [W_BITS-1:0]       j, cons;

    logic [W_BITS-1:0]       pos_i, k;
    logic [FRAC_BITS-1:0]    pos_f;

    logic                    rdy_c, accept, sol_acc, emit, clamp;
    logic                    full, cons_last;

    // Using >= keeps the FSM from stalling if a width of 0 is ever latched.
    assign full      = (cons >= in_q);
    assign cons_last = (({1'b0, cons} + {{W_BITS{1'b0}}, 1'b1}) >= {1'b0, in_q});

    scale_pos_acc #(
        .W_BITS    (W_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_pos_acc (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .clear    (sol_acc),
        .advance  (emit),
        .step     (step_q),
        .pos_int  (pos_i),
        .pos_frac (pos_f),
        .k        (k)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        rdy_c      = 1'b0;
        emit       = 1'b0;
        clamp      = 1'b0;
        accept     = 1'b0;
        sol_acc    = 1'b0;

        case (state)
            IDLE, FILL, DRAIN: rdy_c = 1'b1;
            RUN: begin
                if (k == out_q) begin
                    next_state = full ? IDLE : DRAIN;
                end else if (pos_i == j) begin
                    emit = 1'b1;
                end else if (pos_i > j) begin
                    // Past the last source pixel: repeat it as both neighbours.
                    if (full) begin
                        emit  = 1'b1;
                        clamp = 1'b1;
                    end else begin
                        rdy_c = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase

        accept  = in_vld & rdy_c & ~sys_rst;
        sol_acc = accept & in_sol;

        // A start-of-line in any state aborts the current line and restarts.
        if (sol_acc) begin
            next_state = (cfg_in_width > W_BITS'(1)) ? FILL : RUN;
        end else if (accept) begin
            case (state)
                FILL:    next_state = RUN;
                DRAIN:   if (cons_last) next_state = IDLE;
                default: ;
            endcase
        end
    end

    assign in_rdy = rdy_c & ~sys_rst;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            in_q   <= '0;
            out_q  <= '0;
            step_q <= '0;
            va_q   <= '0;
            vb_q   <= '0;
            keep_q <= 1'b0;
            win0   <= '0;
            win1   <= '0;
            j      <= '0;
            cons   <= '0;
        end else if (sol_acc) begin
            in_q   <= cfg_in_width;
            out_q  <= cfg_out_width;
            step_q <= cfg_step;
            va_q   <= cfg_v_coff_a;
            vb_q   <= cfg_v_coff_b;
            keep_q <= cfg_line_keep;
            win0   <= in_data;
            win1   <= in_data;
            j      <= '0;
            cons   <= W_BITS'(1);
        end else if (accept) begin
            case (state)
                FILL: begin
                    win1 <= in_data;
                    cons <= W_BITS'(2);
                end
                RUN: begin
                    win0 <= win1;
                    win1 <= in_data;
                    j    <= j + W_BITS'(1);
                    cons <= cons + W_BITS'(1);
                end
                DRAIN:   cons <= cons + W_BITS'(1);
                default: ;
            endcase
        end else if (clamp) begin
            win0 <= win1;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            a           <= '0;
            b           <= '0;
            a_coff      <= '0;
            b_coff      <= '0;
            a_coff_next <= '0;
            b_coff_next <= '0;
            data_en     <= 1'b0;
            scale_en    <= 1'b0;
        end else begin
            data_en  <= emit;
            scale_en <= emit & keep_q;
            if (emit) begin
                a           <= clamp ? win1 : win0;
                b           <= win1;
                a_coff      <= COFF_MAX - 8'(pos_f);
                b_coff      <= 8'(pos_f);
                a_coff_next <= va_q;
                b_coff_next <= vb_q;
            end
        end
    end

endmodule
